// File: rtl/blink_pkg.sv
// blink_pkg: shared types and constants for the blink sequencer.
package blink_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    typedef enum logic [1:0] {ROTL, ROTR, BOUNCE} pattern_t;
    typedef enum logic {UP, DOWN} dir_t;
    localparam int LED_W = 3;
    localparam logic [LED_W-1:0] LED_RESET = 3'b110;
endpackage

// File: rtl/blink_sequencer_if.sv
// blink_sequencer_if: board-side buttons and LED/status outputs of the sequencer.
interface blink_sequencer_if;
    import blink_pkg::*;
    logic button_0;
    logic button_1;
    logic [LED_W-1:0] led;
    logic running;
    logic [1:0] speed;
    logic [1:0] pattern;
    modport master (output button_0, button_1, input led, running, speed, pattern);
    modport slave (input button_0, button_1, output led, running, speed, pattern);
endinterface

// File: rtl/blink_sequencer_debounce.sv
// button_debounce: synchronises an active-low button and pulses press on an accepted 1->0 change.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2, level, flip;
    logic [CW-1:0] cnt;
    // flip fires on the edge that completes the run of disagreeing samples
    assign flip = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press = flip && level;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            level <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? s2 : level;
        end
    end
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: button-controlled IDLE/RUN/PAUSE LED pattern sequencer with selectable speed.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int TICK_BASE = 13_500_000
) (
    input logic clk,
    input logic rst_n,
    blink_sequencer_if.slave bus
);
    localparam int TW = $clog2(TICK_BASE + 1);
    state_t state, state_nx;
    pattern_t pat, pat_nx;
    dir_t dir, dir_nx;
    logic [1:0] pos, pos_nx, speed, speed_nx;
    logic [TW-1:0] tcnt, tcnt_nx, period;
    logic p0, p1, spd_evt, step;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b0 (.clk(clk), .rst_n(rst_n), .btn_n(bus.button_0), .press(p0));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b1 (.clk(clk), .rst_n(rst_n), .btn_n(bus.button_1), .press(p1));

    assign period = TW'(TICK_BASE >> speed);

    always_comb begin
        state_nx = state;
        pat_nx = pat;
        dir_nx = dir;
        pos_nx = pos;
        speed_nx = speed;
        tcnt_nx = tcnt;
        // a speed change dominates a coincident step and restarts the period
        spd_evt = (state == RUN) && p1 && !p0;
        step = (state == RUN) && !spd_evt && (tcnt == period - 1'b1);
        if (state == IDLE) tcnt_nx = '0;
        else if (state == RUN) tcnt_nx = (spd_evt || step) ? '0 : tcnt + 1'b1;
        if (spd_evt) speed_nx = speed + 2'd1;
        if (p0) state_nx = (state == RUN) ? PAUSE : RUN;
        else if (state == PAUSE && p1) begin
            pat_nx = (pat == BOUNCE) ? ROTL : pattern_t'(pat + 2'd1);
            dir_nx = UP;
        end
        if (step) begin
            if (pat == ROTL) pos_nx = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
            else if (pat == ROTR) pos_nx = (pos == 2'd0) ? 2'd2 : pos - 2'd1;
            else if (dir == UP) begin
                pos_nx = (pos == 2'd2) ? 2'd1 : pos + 2'd1;
                dir_nx = (pos == 2'd2) ? DOWN : UP;
            end else begin
                pos_nx = (pos == 2'd0) ? 2'd1 : pos - 2'd1;
                dir_nx = (pos == 2'd0) ? UP : DOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pat <= ROTL;
            dir <= UP;
            pos <= 2'd0;
            speed <= 2'd0;
            tcnt <= '0;
        end else begin
            state <= state_nx;
            pat <= pat_nx;
            dir <= dir_nx;
            pos <= pos_nx;
            speed <= speed_nx;
            tcnt <= tcnt_nx;
        end
    end

    assign bus.led = ~(LED_W'(1) << pos);
    assign bus.running = (state == RUN);
    assign bus.speed = speed;
    assign bus.pattern = pat;
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: vector table, latency sequences and randomized run against a behavioural model.
module tb_blink_sequencer;
    localparam int D = 4;
    localparam int TB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    blink_sequencer_if bus();
    blink_sequencer #(.DEBOUNCE_CYCLES(D), .TICK_BASE(TB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    string tag = "init";

    typedef struct {
        bit b0, b1, rn;
        int n;
        logic [2:0] led;
        bit run;
        logic [1:0] spd, pat;
    } vec_t;
    vec_t vecs[$];

    // behavioural model: pin history queues, sample windows, plain integer state
    int hist[2][$];
    int win[2][$];
    int lvl[2];
    int ms, pos, dir, spd, pat, ph;
    logic [2:0] led_tab[3] = '{3'b110, 3'b101, 3'b011};

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            hist[b] = {1, 1};
            win[b].delete();
            for (int i = 0; i < D; i++) win[b].push_back(1);
            lvl[b] = 1;
        end
        ms = 0; pos = 0; dir = 0; spd = 0; pat = 0; ph = 0;
    endfunction

    function automatic logic [7:0] model_out();
        return {led_tab[pos], ms == 1, 2'(spd), 2'(pat)};
    endfunction

    task automatic deb_edge(input int b, input int pin, output bit ev);
        int s;
        bit all_diff;
        hist[b].push_back(pin);
        s = hist[b].pop_front();
        win[b].push_back(s);
        if (win[b].size() > D) void'(win[b].pop_front());
        all_diff = 1;
        foreach (win[b][i]) if (win[b][i] == lvl[b]) all_diff = 0;
        ev = 0;
        if (all_diff) begin
            lvl[b] = 1 - lvl[b];
            ev = (lvl[b] == 0);
        end
    endtask

    task automatic advance();
        if (pat == 0) pos = (pos + 1) % 3;
        else if (pat == 1) pos = (pos + 2) % 3;
        else if (dir == 0) begin
            if (pos < 2) pos++; else begin pos = 1; dir = 1; end
        end else begin
            if (pos > 0) pos--; else begin pos = 1; dir = 0; end
        end
    endtask

    task automatic model_edge(input bit b0, input bit b1, input bit rn);
        bit e0, e1;
        int per;
        if (!rn) begin
            model_reset();
            return;
        end
        deb_edge(0, b0, e0);
        deb_edge(1, b1, e1);
        per = TB >> spd;
        if (ms == 0) begin
            ph = 0;
            if (e0) ms = 1;
        end else if (ms == 1) begin
            if (e1 && !e0) begin spd = (spd + 1) % 4; ph = 0; end
            else if (ph == per - 1) begin ph = 0; advance(); end
            else ph++;
            if (e0) ms = 2;
        end else begin
            if (e0) ms = 1;
            else if (e1) begin pat = (pat + 1) % 3; dir = 0; end
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={led,run,spd,pat}=%b required=%b", name, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.led, bus.running, bus.speed, bus.pattern};
    endfunction

    task automatic cyc(input bit b0, input bit b1, input bit rn);
        bus.button_0 = b0;
        bus.button_1 = b1;
        rst_n = rn;
        @(posedge clk);
        model_edge(b0, b1, rn);
        @(negedge clk);
        check(tag, dut_out(), model_out());
    endtask

    initial begin
        int lat, changes;
        logic prev_run;
        bus.button_0 = 1'b1;
        bus.button_1 = 1'b1;
        model_reset();

        vecs.push_back('{1, 1, 0, 3,  3'b110, 0, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 5,  3'b110, 0, 2'd0, 2'd0});
        vecs.push_back('{0, 1, 1, 3,  3'b110, 0, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 10, 3'b110, 0, 2'd0, 2'd0});
        vecs.push_back('{0, 1, 1, 10, 3'b110, 1, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 12, 3'b101, 1, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 16, 3'b011, 1, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 16, 3'b110, 1, 2'd0, 2'd0});
        vecs.push_back('{1, 0, 1, 10, 3'b110, 1, 2'd1, 2'd0});
        vecs.push_back('{1, 1, 1, 4,  3'b101, 1, 2'd1, 2'd0});
        vecs.push_back('{0, 1, 1, 10, 3'b101, 0, 2'd1, 2'd0});
        vecs.push_back('{1, 1, 1, 50, 3'b101, 0, 2'd1, 2'd0});
        vecs.push_back('{1, 0, 1, 10, 3'b101, 0, 2'd1, 2'd1});
        vecs.push_back('{1, 1, 1, 10, 3'b101, 0, 2'd1, 2'd1});
        vecs.push_back('{1, 0, 1, 10, 3'b101, 0, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 1, 10, 3'b101, 0, 2'd1, 2'd2});
        vecs.push_back('{0, 1, 1, 10, 3'b011, 1, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 1, 6,  3'b101, 1, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 1, 8,  3'b110, 1, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 1, 8,  3'b101, 1, 2'd1, 2'd2});
        vecs.push_back('{0, 0, 1, 10, 3'b101, 0, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 1, 10, 3'b101, 0, 2'd1, 2'd2});
        vecs.push_back('{0, 1, 1, 10, 3'b011, 1, 2'd1, 2'd2});
        vecs.push_back('{1, 1, 0, 1,  3'b110, 0, 2'd0, 2'd0});
        vecs.push_back('{1, 1, 1, 5,  3'b110, 0, 2'd0, 2'd0});

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d_cycle", i);
            repeat (vecs[i].n) cyc(vecs[i].b0, vecs[i].b1, vecs[i].rn);
            check($sformatf("vec%0d_end", i), dut_out(), {vecs[i].led, vecs[i].run, vecs[i].spd, vecs[i].pat});
        end

        // press latency from the pin falling, then a long hold must toggle the state only once
        tag = "hold_cycle";
        lat = 0;
        while (!bus.running && lat < 20) begin
            cyc(0, 1, 1);
            lat++;
        end
        check("start_latency", 8'(lat), 8'd6);
        changes = 0;
        prev_run = bus.running;
        for (int i = lat; i < 100; i++) begin
            cyc(0, 1, 1);
            if (bus.running !== prev_run) changes++;
            prev_run = bus.running;
        end
        repeat (10) cyc(1, 1, 1);
        check("hold_changes", 8'(changes), 8'd0);
        check("hold_running", {7'd0, bus.running}, 8'd1);

        tag = "rand_cycle";
        for (int it = 0; it < 220; it++) begin
            bit b0, b1, rn;
            int dur;
            b0 = ($urandom_range(0, 2) != 0);
            b1 = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 60) != 0);
            dur = (b0 && b1) ? $urandom_range(1, 40) : $urandom_range(1, 14);
            if (!rn) dur = 1;
            repeat (dur) cyc(b0, b1, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
